inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Parametrised successor to the single-register PC fetch stage.
- Decouples PC generation from decode using a DEPTH-entry in-order prefetch queue.
- Memory side uses a valid/ready request channel and an in-order response channel; decode side uses a valid/ready pop interface.
- Handles prioritised redirects (trap, mret, EX branch, optional BPU) with queue flush and discard of stale in-flight responses. Sits between the instruction memory/ITLB and the IF_ID register.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, queue entries; also the maximum number of outstanding memory requests; power of 2, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- PC_STEP, 4, increment per accepted request.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- trap_req  in  1  redirect to csr_mtvec (ecall/ebreak/IRQ).
- csr_mtvec  in  XLEN  trap target.
- mret_req  in  1  redirect to csr_mepc.
- csr_mepc  in  XLEN  mret target.
- br_taken  in  1  EX-stage resolved branch/jump redirect.
- br_target  in  XLEN  EX-stage target.
- bpu_taken  in  1  predicted-taken redirect (only with FETCH_BPU_EN).
- bpu_target  in  XLEN  predicted target (only with FETCH_BPU_EN).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid, in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode consumes head.
- if_pc  out  XLEN  PC of head.
- if_pc4  out  XLEN  if_pc + PC_STEP.
- if_inst  out  XLEN  instruction at head.
- outstanding  out  log2(DEPTH)+1  in-flight accepted requests (debug/perf).

Behaviour:
- Reset (RST_N low, async): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req_valid=0; if_valid=0; if_pc=0; if_pc4=0; if_inst=0.
- Credit: imem_req_valid = (count + outstanding < DEPTH) && !redirect, where redirect = OR of active redirect inputs. imem_req_valid never depends on imem_req_ready. imem_req_addr = fetch_pc.
- Accept (valid & ready): fetch_pc += PC_STEP (mod 2^XLEN, wraps); PC of the request is pushed onto an internal pc-tag FIFO; outstanding++.
- Response: outstanding--. If drop_cnt>0, the response is discarded and drop_cnt--. Otherwise {tag pc, data} is pushed onto the queue.
  - Responses arriving with outstanding==0 are a protocol error and are ignored.
- Pop: if_valid = count>0; head pops on if_valid & if_ready. Outputs are combinational from the head entry; if_pc/if_pc4/if_inst hold the last head value when empty.
- Push and pop in the same cycle are permitted; count is unchanged. Credit rule guarantees no overflow, including when full.
- Redirect priority: trap_req > mret_req > br_taken > bpu_taken. Only the winner's target is used; target[1:0] is forced to 2'b00.
- On a redirect cycle:
  - fetch_pc <= target; queue cleared; pc-tag FIFO cleared.
  - drop_cnt <= outstanding - (response this cycle ? 1 : 0).
  - No request is issued; if_valid is forced 0 that cycle.
  - First request to the target is issued the next cycle.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding; the last target wins.
- Latency: redirect to imem_req_valid at target is 1 cycle. Response to if_valid is 1 cycle (registered queue write).
- Reset asserted mid-transaction clears all state; late memory responses after reset are ignored (outstanding==0).

Optional Feature:
- FETCH_BPU_EN defined: bpu_taken/bpu_target take part in redirect priority as the lowest-priority source. A bpu redirect flushes only requests younger than the predicted branch: queue contents are retained and drop_cnt counts only in-flight requests.
- FETCH_BPU_EN undefined: bpu ports are absent and fetch is strictly sequential except for trap/mret/branch.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle memory, if_ready=1 -> addrs 0x0,0x4,0x8… issued every cycle; if_pc follows at +2 cycles; if_pc4 = if_pc+4.
- if_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; release if_ready -> 4 pops in order with no loss or duplication.
- 3 requests in flight, br_taken=1, br_target=0x100 -> queue empty, 3 stale responses dropped, next if_pc=0x100.
- trap_req and br_taken in the same cycle, mtvec=0x200, br_target=0x100 -> next imem_req_addr=0x200.
- mret_req, mepc=0x1236 -> imem_req_addr=0x1234.
- RST_N pulsed low mid-fetch with 2 outstanding -> all outputs 0 immediately; first post-reset request addr=RESET_PC; late responses ignored.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// In-order instruction prefetch queue: credit-limited memory requests, in-order responses, prioritised redirects.
// Optional macro FETCH_BPU_EN adds the predicted-taken redirect source (bpu_taken/bpu_target).
module inst_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   trap_req,
    input  logic [XLEN-1:0]        csr_mtvec,
    input  logic                   mret_req,
    input  logic [XLEN-1:0]        csr_mepc,
    input  logic                   br_taken,
    input  logic [XLEN-1:0]        br_target,
`ifdef FETCH_BPU_EN
    input  logic                   bpu_taken,
    input  logic [XLEN-1:0]        bpu_target,
`endif
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [XLEN-1:0]        imem_rsp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [XLEN-1:0]        if_pc,
    output logic [XLEN-1:0]        if_pc4,
    output logic [XLEN-1:0]        if_inst,
    output logic [$clog2(DEPTH):0] outstanding
);

    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam int unsigned    CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  q_pc_q   [DEPTH];
    logic [XLEN-1:0]  q_inst_q [DEPTH];
    logic [XLEN-1:0]  tag_q    [DEPTH];
    logic [PTR_W-1:0] q_wr_q, q_wr_d;
    logic [PTR_W-1:0] q_rd_q, q_rd_d;
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [XLEN-1:0]  hold_pc_q, hold_pc4_q, hold_inst_q;

    logic             redirect;
    logic             flush_queue;
    logic [XLEN-1:0]  redir_target;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_drop;
    logic             q_push;
    logic             q_pop;
    logic             q_nonempty;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_inst;

    // Only the highest-priority active source steers fetch; a predicted redirect keeps the queue.
    always_comb begin
        redirect     = 1'b0;
        flush_queue  = 1'b0;
        redir_target = '0;
        if (trap_req) begin
            redirect     = 1'b1;
            flush_queue  = 1'b1;
            redir_target = csr_mtvec;
        end else if (mret_req) begin
            redirect     = 1'b1;
            flush_queue  = 1'b1;
            redir_target = csr_mepc;
        end else if (br_taken) begin
            redirect     = 1'b1;
            flush_queue  = 1'b1;
            redir_target = br_target;
        end
`ifdef FETCH_BPU_EN
        else if (bpu_taken) begin
            redirect     = 1'b1;
            redir_target = bpu_target;
        end
`endif
    end

    assign credit_ok      = ({1'b0, q_cnt_q} + {1'b0, out_q}) < DEPTH_LIM;
    assign imem_req_valid = RST_N && credit_ok && !redirect;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored outright.
    assign rsp_fire   = imem_rsp_valid && (out_q != '0);
    assign rsp_drop   = rsp_fire && (drop_q != '0);
    assign q_push     = rsp_fire && !rsp_drop && !flush_queue;

    assign q_nonempty = (q_cnt_q != '0);
    assign if_valid   = q_nonempty && !redirect;
    assign q_pop      = if_valid && if_ready;

    assign head_pc     = q_pc_q[q_rd_q];
    assign head_inst   = q_inst_q[q_rd_q];
    assign if_pc       = q_nonempty ? head_pc : hold_pc_q;
    assign if_pc4      = q_nonempty ? head_pc + XLEN'(PC_STEP) : hold_pc4_q;
    assign if_inst     = q_nonempty ? head_inst : hold_inst_q;
    assign outstanding = out_q;

    // Next-state for pointers and counters; a redirect overrides the normal bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        q_wr_d     = q_wr_q;
        q_rd_d     = q_rd_q;
        q_cnt_d    = q_cnt_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        out_d      = out_q;
        drop_d     = drop_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            tag_wr_d   = tag_wr_q + PTR_W'(1);
        end
        if (rsp_fire && !rsp_drop) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end
        if (rsp_drop) begin
            drop_d = drop_q - CNT_W'(1);
        end

        case ({req_fire, rsp_fire})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase

        if (q_push) begin
            q_wr_d = q_wr_q + PTR_W'(1);
        end
        if (q_pop) begin
            q_rd_d = q_rd_q + PTR_W'(1);
        end
        case ({q_push, q_pop})
            2'b10:   q_cnt_d = q_cnt_q + CNT_W'(1);
            2'b01:   q_cnt_d = q_cnt_q - CNT_W'(1);
            default: q_cnt_d = q_cnt_q;
        endcase

        // Every request still in flight belongs to the abandoned path.
        if (redirect) begin
            fetch_pc_d = redir_target & ~XLEN'(3);
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            drop_d     = out_q - CNT_W'(rsp_fire);
            if (flush_queue) begin
                q_wr_d  = '0;
                q_rd_d  = '0;
                q_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc_q  <= RESET_PC;
            q_wr_q      <= '0;
            q_rd_q      <= '0;
            q_cnt_q     <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            out_q       <= '0;
            drop_q      <= '0;
            hold_pc_q   <= '0;
            hold_pc4_q  <= '0;
            hold_inst_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            q_cnt_q    <= q_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            if (q_nonempty) begin
                hold_pc_q   <= head_pc;
                hold_pc4_q  <= head_pc + XLEN'(PC_STEP);
                hold_inst_q <= head_inst;
            end
        end
    end

    // Storage arrays are qualified by the counters, so they need no reset.
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (q_push) begin
            q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
            q_inst_q[q_wr_q] <= imem_rsp_data;
        end
    end

endmodule
